// File: rtl/linear_pkg.sv
`default_nettype none
// ============================================================================
// Module      : linear_pkg
// Description : Shared types, frame constants and helpers for the linear
//               operand path (feeder -> multiplier_top).
// Revision    : 1.0 - initial release
// ============================================================================
package linear_pkg;

    localparam int PRECISION      = 8;
    localparam int BIAS_PRECISION = 32;
    localparam int NUM_FEATURES   = 2;
    localparam int N              = 16;

    // One weight vector followed by NUM_FEATURES feature vectors.
    localparam int FRAME_LEN      = N * (NUM_FEATURES + 1);

    typedef logic [PRECISION-1:0]      byte_t;
    typedef logic [BIAS_PRECISION-1:0] bias_t;

    // Width of a counter that indexes 0..len-1; never narrower than 1 bit.
    function automatic int cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/linear_input_feeder.sv
`default_nettype none
// ============================================================================
// Module      : linear_input_feeder
// Description : Deserializes a byte stream into one weight vector and
//               NUM_FEATURES feature vectors, presents them on registered
//               parallel outputs with a bias, and pulses ce per good frame.
// Revision    : 1.0 - initial release
// ============================================================================
module linear_input_feeder #(
    parameter int PRECISION      = 8,
    parameter int BIAS_PRECISION = 32,
    parameter int NUM_FEATURES   = 2,
    parameter int N              = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [PRECISION-1:0]      s_data,
    input  logic                      s_valid,
    input  logic                      s_last,
    output logic                      s_ready,
    input  logic [BIAS_PRECISION-1:0] bias_in,
    input  logic                      bias_load,
    output logic [PRECISION-1:0]      weights_out  [N],
    output logic [PRECISION-1:0]      features_out [NUM_FEATURES][N],
    output logic [BIAS_PRECISION-1:0] bias_out,
    output logic                      ce,
    output logic                      frame_err
);
    import linear_pkg::*;

    localparam int             FLEN     = N * (NUM_FEATURES + 1);
    localparam int             CW       = cnt_width(FLEN);
    localparam logic [CW-1:0]  LAST_IDX = CW'(FLEN - 1);

    // The counter alone encodes the load phase: below N it addresses weights,
    // above it addresses features, so no separate state register is kept.
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [PRECISION-1:0] shadow_q [FLEN];
    logic [PRECISION-1:0] w_frame  [FLEN];
    logic                 w_hs;
    logic                 w_at_last;
    logic                 w_frame_ok;
    logic                 w_frame_bad;

    assign s_ready     = en;
    assign w_hs        = s_valid && en;
    assign w_at_last   = (cnt_q == LAST_IDX);
    assign w_frame_ok  = w_hs && w_at_last && s_last;
    // Either an early s_last or a missing one on the final slot.
    assign w_frame_bad = w_hs && (w_at_last ^ s_last);

    // Next byte position: wrap on any frame end (good or bad), else step.
    always_comb begin
        cnt_d = cnt_q;
        if (w_hs) begin
            cnt_d = (w_at_last || s_last) ? '0 : cnt_q + 1'b1;
        end
    end

    // Complete frame image: shadow bytes plus the byte arriving this cycle,
    // so outputs update on the same edge as the final handshake.
    always_comb begin
        w_frame           = shadow_q;
        w_frame[FLEN-1]   = s_data;
    end

    // Counter, shadow capture, output publish, bias and status pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q     <= '0;
            ce        <= 1'b0;
            frame_err <= 1'b0;
            bias_out  <= '0;
            for (int k = 0; k < FLEN; k++) begin
                shadow_q[k] <= '0;
            end
            for (int i = 0; i < N; i++) begin
                weights_out[i] <= '0;
            end
            for (int f = 0; f < NUM_FEATURES; f++) begin
                for (int i = 0; i < N; i++) begin
                    features_out[f][i] <= '0;
                end
            end
        end else begin
            cnt_q     <= cnt_d;
            ce        <= w_frame_ok;
            frame_err <= w_frame_bad;

            if (bias_load) begin
                bias_out <= bias_in;
            end

            if (w_hs && !w_at_last && !s_last) begin
                shadow_q[cnt_q] <= s_data;
            end

            if (w_frame_ok) begin
                for (int i = 0; i < N; i++) begin
                    weights_out[i] <= w_frame[i];
                end
                for (int f = 0; f < NUM_FEATURES; f++) begin
                    for (int i = 0; i < N; i++) begin
                        features_out[f][i] <= w_frame[N + f*N + i];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_linear_input_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_linear_input_feeder
// Description : Scoreboard bench for linear_input_feeder: the driver pushes
//               expected frame/error events, a monitor pops them on ce or
//               frame_err and also checks that outputs hold between events.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_linear_input_feeder;

    localparam int P    = 8;
    localparam int B    = 32;
    localparam int NF   = 2;
    localparam int N    = 16;
    localparam int FLEN = N * (NF + 1);

    typedef struct packed {
        logic                       is_err;
        logic [31:0]                cyc;
        logic [N-1:0][7:0]          w;
        logic [NF-1:0][N-1:0][7:0]  f;
        logic [31:0]                bias;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [P-1:0]  s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [B-1:0]  bias_in;
    logic          bias_load;
    logic [P-1:0]  weights_out  [N];
    logic [P-1:0]  features_out [NF][N];
    logic [B-1:0]  bias_out;
    logic          ce;
    logic          frame_err;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   cyc    = 0;
    logic [31:0]   cur_bias;
    logic [7:0]    fr1 [FLEN];
    logic [7:0]    fr2 [FLEN];
    exp_t          sb [$];

    linear_input_feeder #(
        .PRECISION      (P),
        .BIAS_PRECISION (B),
        .NUM_FEATURES   (NF),
        .N              (N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .bias_in      (bias_in),
        .bias_load    (bias_load),
        .weights_out  (weights_out),
        .features_out (features_out),
        .bias_out     (bias_out),
        .ce           (ce),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] get_byte(input int sel, input int k);
        return (sel == 1) ? fr1[k] : fr2[k];
    endfunction

    function automatic exp_t build_exp(input int sel);
        exp_t e;
        e = '0;
        for (int i = 0; i < N; i++) begin
            e.w[i] = get_byte(sel, i);
            for (int f = 0; f < NF; f++) begin
                e.f[f][i] = get_byte(sel, N + f*N + i);
            end
        end
        return e;
    endfunction

    // Drive nbytes of frame 'sel'; s_last on byte last_at (-1 = never).
    task automatic send_frame(input int sel, input int last_at, input int nbytes,
                              input bit gaps, input bit bias_last, input logic [31:0] bval);
        exp_t e;
        for (int k = 0; k < nbytes; k++) begin
            if (gaps) begin
                for (int g = 0; g < 4 && $urandom_range(0, 9) < 3; g++) begin
                    if ($urandom_range(0, 1) == 0) begin
                        s_valid = 1'b0; en = 1'b1;
                    end else begin
                        // Stalled by en: junk data and s_last must be ignored.
                        s_valid = 1'b1; en = 1'b0; s_last = 1'b1; s_data = 8'hEE;
                    end
                    @(posedge clk); #1;
                    s_last = 1'b0;
                end
            end
            en      = 1'b1;
            s_valid = 1'b1;
            s_data  = get_byte(sel, k);
            s_last  = (k == last_at);
            if (bias_last && k == nbytes - 1) begin
                bias_in   = bval;
                bias_load = 1'b1;
                cur_bias  = bval;
            end
            if ((k == last_at && k < FLEN - 1) || k == FLEN - 1) begin
                e        = build_exp(sel);
                e.is_err = !(k == FLEN - 1 && last_at == FLEN - 1);
                e.cyc    = cyc + 1;
                e.bias   = cur_bias;
                sb.push_back(e);
            end
            @(posedge clk); #1;
            s_valid   = 1'b0;
            s_last    = 1'b0;
            bias_load = 1'b0;
        end
    endtask

    task automatic load_bias(input logic [31:0] v);
        bias_in   = v;
        bias_load = 1'b1;
        cur_bias  = v;
        @(posedge clk); #1;
        bias_load = 1'b0;
    endtask

    // Monitor: reset contents, event scoreboard, hold-between-events checks.
    initial begin : monitor
        logic                      rst_seen;
        logic [N-1:0][7:0]         aw;
        logic [NF-1:0][N-1:0][7:0] af;
        logic [N-1:0][7:0]         mw;
        logic [NF-1:0][N-1:0][7:0] mf;
        exp_t                      e;
        mw = '0;
        mf = '0;
        forever begin
            @(posedge clk);
            rst_seen = rst;
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                aw[i] = weights_out[i];
                for (int f = 0; f < NF; f++) begin
                    af[f][i] = features_out[f][i];
                end
            end
            if (rst_seen !== 1'b1) begin
                mw = '0;
                mf = '0;
                chk("rst_weights", aw, 0);
                chk("rst_features", af, 0);
                chk("rst_bias", bias_out, 0);
                chk("rst_ce", ce, 0);
                chk("rst_frame_err", frame_err, 0);
            end else if (ce === 1'b1 || frame_err === 1'b1) begin
                chk("ce_err_exclusive", ce & frame_err, 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got ce=%0b frame_err=%0b expected none (cycle %0d)",
                             ce, frame_err, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind_err", frame_err, e.is_err);
                    chk("event_cycle", cyc, e.cyc);
                    chk("event_bias", bias_out, e.bias);
                    if (!e.is_err) begin
                        chk("frame_weights", aw, e.w);
                        chk("frame_features", af, e.f);
                        mw = e.w;
                        mf = e.f;
                    end else begin
                        chk("err_hold_weights", aw, mw);
                        chk("err_hold_features", af, mf);
                    end
                end
            end else begin
                chk("hold_weights", aw, mw);
                chk("hold_features", af, mf);
                chk("s_ready", s_ready, en);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion expected finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin : driver
        for (int i = 0; i < N; i++) begin
            fr1[i]        = 8'((i % 8) + 1);
            fr1[N + i]    = 8'h01;
            fr1[2*N + i]  = 8'h02;
            fr2[i]        = (i < 15) ? 8'((i + 1) * 16) : 8'h01;
            fr2[N + i]    = 8'h05;
            fr2[2*N + i]  = 8'h0A;
        end
        rst = 1'b0; en = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        s_data = '0; bias_in = '0; bias_load = 1'b0; cur_bias = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Single frame with a bias preload.
        load_bias(32'h10);
        chk("bias_loaded", bias_out, 32'h10);
        send_frame(1, FLEN-1, FLEN, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back frames at one byte per cycle.
        send_frame(1, FLEN-1, FLEN, 1'b0, 1'b0, 0);
        send_frame(2, FLEN-1, FLEN, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;

        // Gapped stream via both s_valid and en.
        send_frame(1, FLEN-1, FLEN, 1'b1, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;

        // Early s_last at byte 20, then a good frame.
        send_frame(2, 20, 21, 1'b0, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        send_frame(2, FLEN-1, FLEN, 1'b0, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;

        // Missing s_last on byte 47, then a good frame straight after.
        send_frame(1, -1, FLEN, 1'b0, 1'b0, 0);
        send_frame(1, FLEN-1, FLEN, 1'b0, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-frame at byte 30, then a full frame with bias on last byte.
        send_frame(2, -1, 30, 1'b0, 1'b0, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst      = 1'b1;
        cur_bias = '0;
        @(posedge clk); #1;
        send_frame(2, FLEN-1, FLEN, 1'b0, 1'b1, 32'hCAFE_F00D);

        for (int t = 0; t < 20 && sb.size() != 0; t++) begin
            @(posedge clk);
        end
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        chk("final_bias", bias_out, 32'hCAFE_F00D);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/linear_input_feeder.md
Name: linear_input_feeder

Overview:
- Producer side of the multiplier_top operand interface: deserializes a byte stream into one N-element weight vector plus NUM_FEATURES N-element feature vectors.
- Presents the assembled operands, with bias, on registered parallel outputs and pulses ce for exactly one cycle per completed frame.
- Sits between the DMA/BRAM byte streamer and multiplier_top; decouples serial arrival from the parallel compute datapath.

Parameters:
- PRECISION, 8, operand byte width in bits.
- BIAS_PRECISION, 32, bias width in bits.
- NUM_FEATURES, 2, number of feature vectors per frame.
- N, 16, elements per vector.

Ports:
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-low reset.
- en, in, 1, accept enable; s_ready = en.
- s_data, in, PRECISION, stream byte.
- s_valid, in, 1, byte valid.
- s_last, in, 1, marks the final byte of a frame.
- s_ready, out, 1, byte accepted when s_valid && s_ready.
- bias_in, in, BIAS_PRECISION, bias value.
- bias_load, in, 1, loads bias_in into bias_out.
- weights_out, out, N x PRECISION unpacked, weight vector.
- features_out, out, NUM_FEATURES x N x PRECISION unpacked, feature vectors.
- bias_out, out, BIAS_PRECISION, registered bias.
- ce, out, 1, one-cycle pulse: a new frame is valid on the outputs.
- frame_err, out, 1, one-cycle pulse on a framing error.

Behaviour:
- Reset (rst=0 at a clk edge): all outputs, shadow registers and counters go to 0; ce=0; frame_err=0. Reset mid-frame discards the partial frame.
- Frame layout, FRAME_LEN = N*(NUM_FEATURES+1) bytes:
  - Bytes 0..N-1 are weights[0..N-1].
  - Then feature f, element i, at byte N + f*N + i.
- Byte counter: width $clog2(FRAME_LEN). Increments per handshake. Captured bytes go to shadow registers only; output registers are untouched during assembly.
- States: LOAD_W (cnt < N) and LOAD_F (N <= cnt < FRAME_LEN). The transition is implied by the counter; no dead cycles.
- Frame complete (handshake at cnt = FRAME_LEN-1 with s_last=1):
  - On the same edge, weights_out and features_out load shadow plus the final byte, and cnt wraps to 0.
  - ce=1 for exactly the following cycle.
  - Latency: ce is high 1 cycle after the last byte's handshake edge.
  - Back-to-back frames are sustained at 1 byte/cycle with no stall.
- Framing errors:
  - s_last=1 at cnt < FRAME_LEN-1: discard the frame, cnt := 0, frame_err pulse, no ce.
  - s_last=0 at cnt = FRAME_LEN-1: discard the frame, cnt := 0, frame_err pulse, no ce. The next byte starts a new frame.
  - Outputs keep the last good frame in both cases.
- Backpressure: s_valid=0 or en=0 freezes cnt and shadow; gaps are allowed anywhere in a frame.
- Bias: bias_load=1 updates bias_out on the next edge, independent of the stream.
  - If the load coincides with a frame-complete edge, the new bias is visible in the same cycle as ce.
  - Bias is never cleared by framing errors.
- Outputs are stable between ce pulses. multiplier_top samples them only while ce=1.

Decomposition:
- Add to the shared linear_pkg:
  - typedef byte_t = logic [PRECISION-1:0].
  - typedef bias_t.
  - localparam FRAME_LEN.
  - Counter width function.
- No sub-module is warranted: a single always_ff for counter/shadow/outputs plus combinational s_ready.

Test Plan:
- Reset then one frame: weights 01..08,01..08; feature0 all 01; feature1 all 02; s_last on byte 47; bias_load with 10 -> ce pulses 1 cycle after byte 47; outputs match; bias_out = 10.
- Back-to-back frames: frame 1 as above, then weights 10,20,...,F0,01, feature0 all 05, feature1 all 0A, continuous valid -> two ce pulses 48 cycles apart; second output set exact; outputs hold between pulses.
- Random s_valid/en gaps (~30% idle) over a frame -> identical outputs to the gapless case; ce occurs exactly once, after byte 47.
- Early s_last at byte 20 -> frame_err pulse, no ce, outputs unchanged; the following correct frame yields ce and correct data.
- Missing s_last at byte 47 -> frame_err, no ce; the next good frame is accepted.
- rst=0 asserted at byte 30 -> all outputs 0; a subsequent full frame produces ce and correct data. Also: bias_load coinciding with the last byte -> new bias visible with ce.
